// File: rtl/branch_predictor_if.sv
// Fetch/execute signal bundle for branch_predictor.
// The predictor side uses the slave modport; the pipeline side uses master.
`ifndef RF_XLEN
`define RF_XLEN 32
`endif

interface branch_predictor_if #(
  parameter int XLEN = `RF_XLEN
);
  logic            if_valid;
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            ex_valid;
  logic            ex_is_branch;
  logic [XLEN-1:0] ex_pc;
  logic            ex_br_taken;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output if_valid, if_pc,
    output ex_valid, ex_is_branch, ex_pc, ex_br_taken, ex_target,
    output ex_pred_taken, ex_pred_target,
    input  pred_taken, pred_target, redirect, redirect_pc
  );

  modport slave (
    input  if_valid, if_pc,
    input  ex_valid, ex_is_branch, ex_pc, ex_br_taken, ex_target,
    input  ex_pred_taken, ex_pred_target,
    output pred_taken, pred_target, redirect, redirect_pc
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter predictor with execute-side mispredict redirect.
// Optional macro BP_STATS_EN adds saturating branch/mispredict counters.
`ifndef RF_XLEN
`define RF_XLEN 32
`endif

module branch_predictor #(
  parameter  int XLEN    = `RF_XLEN,
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_predictor_if.slave    bp
`ifdef BP_STATS_EN
  ,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
`endif
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  // Fetch-side lookup: purely combinational from registered table state
  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic             pred_taken;

  assign if_idx     = bp.if_pc[IDX_W+1:2];
  assign if_tag     = bp.if_pc[XLEN-1:IDX_W+2];
  assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken = bp.if_valid && if_hit && ctr_q[if_idx][1];

  assign bp.pred_taken  = pred_taken;
  assign bp.pred_target = pred_taken ? target_q[if_idx] : bp.if_pc + XLEN'(4);

  // Execute-side resolution
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [XLEN-1:0]  actual_next;
  logic             mispredict;

  assign ex_idx      = bp.ex_pc[IDX_W+1:2];
  assign ex_tag      = bp.ex_pc[XLEN-1:IDX_W+2];
  assign ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign actual_next = (bp.ex_is_branch && bp.ex_br_taken) ? bp.ex_target
                                                           : bp.ex_pc + XLEN'(4);
  assign mispredict  = bp.ex_valid && (actual_next != bp.ex_pred_target);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic             valid_reg;
      logic [TAG_W-1:0] tag_reg;
      logic [XLEN-1:0]  target_reg;
      logic [1:0]       ctr_reg;
      logic             sel;

      assign sel = bp.ex_valid && (ex_idx == IDX_W'(gi));

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg  <= 1'b0;
          tag_reg    <= '0;
          target_reg <= '0;
          ctr_reg    <= 2'b01;
        end else if (sel) begin
          if (bp.ex_is_branch) begin
            if (ex_hit) begin
              if (bp.ex_br_taken) begin
                if (ctr_reg != 2'b11) ctr_reg <= ctr_reg + 2'b01;
                target_reg <= bp.ex_target;
              end else if (ctr_reg != 2'b00) begin
                ctr_reg <= ctr_reg - 2'b01;
              end
            end else if (bp.ex_br_taken) begin
              // Allocation evicts whatever lived at this index
              valid_reg  <= 1'b1;
              tag_reg    <= ex_tag;
              target_reg <= bp.ex_target;
              ctr_reg    <= 2'b10;
            end
          end else if (bp.ex_pred_taken && ex_hit) begin
            valid_reg <= 1'b0;
          end
        end
      end

      assign valid_q[gi]  = valid_reg;
      assign tag_q[gi]    = tag_reg;
      assign target_q[gi] = target_reg;
      assign ctr_q[gi]    = ctr_reg;
    end
  endgenerate

  logic            redirect_reg;
  logic [XLEN-1:0] redirect_pc_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      redirect_reg <= mispredict;
      if (mispredict) redirect_pc_reg <= actual_next;
    end
  end

  assign bp.redirect    = redirect_reg;
  assign bp.redirect_pc = redirect_pc_reg;

`ifdef BP_STATS_EN
  logic [31:0] stat_branches_reg;
  logic [31:0] stat_mispredicts_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_reg    <= '0;
      stat_mispredicts_reg <= '0;
    end else begin
      if (bp.ex_valid && bp.ex_is_branch && (stat_branches_reg != 32'hFFFF_FFFF))
        stat_branches_reg <= stat_branches_reg + 32'd1;
      // Counted on the edge that raises redirect
      if (mispredict && (stat_mispredicts_reg != 32'hFFFF_FFFF))
        stat_mispredicts_reg <= stat_mispredicts_reg + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_reg;
  assign stat_mispredicts = stat_mispredicts_reg;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized scoreboard bench for branch_predictor against a table-level reference model.
// Define BP_STATS_EN to also check the statistics counters.
module tb_branch_predictor;
  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(XLEN)) bp ();
`ifdef BP_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;
`endif

  branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
`ifdef BP_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  // Reference model: one record per BTB slot, counter as plain integer 0..3
  bit          m_valid  [ENTRIES];
  logic [31:0] m_tag    [ENTRIES];
  logic [31:0] m_target [ENTRIES];
  int          m_ctr    [ENTRIES];
  logic [31:0] m_branches, m_misp;

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [31:0] m_tagof(input logic [31:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_ctr[i] = 1;
    end
    m_branches = 0;
    m_misp     = 0;
  endfunction

  function automatic void m_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
    int i;
    i  = m_idx(pc);
    t  = m_valid[i] && (m_tag[i] == m_tagof(pc)) && (m_ctr[i] >= 2);
    tg = t ? m_target[i] : pc + 32'd4;
  endfunction

  typedef struct {
    int          due;
    bit          taken;
    logic [31:0] target;
    string       name;
  } pred_exp_t;

  typedef struct {
    int          due;
    bit          redirect;
    bit          chk_pc;
    logic [31:0] pc;
    logic [31:0] br;
    logic [31:0] mp;
    string       name;
  } rd_exp_t;

  pred_exp_t pq[$];
  rd_exp_t   rq[$];
  int        cyc = 0;
  bit        done = 0;
  int        n_checks = 0;
  int        n_pass = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Monitor: pops expectations that fall due this cycle and compares
  initial begin
    pred_exp_t pe;
    rd_exp_t   re;
    bit        ok;
    forever begin
      @(negedge clk);
      while (pq.size() > 0 && pq[0].due == cyc) begin
        pe = pq.pop_front();
        n_checks++;
        if (bp.pred_taken === pe.taken && bp.pred_target === pe.target) begin
          n_pass++;
          $display("[%0d] pred %-14s taken=%0b target=%08h ok", cyc, pe.name, bp.pred_taken, bp.pred_target);
        end else
          $display("[%0d] FAIL pred %s: got taken=%0b target=%08h, want taken=%0b target=%08h",
                   cyc, pe.name, bp.pred_taken, bp.pred_target, pe.taken, pe.target);
      end
      while (rq.size() > 0 && rq[0].due == cyc) begin
        re = rq.pop_front();
        n_checks++;
        ok = (bp.redirect === re.redirect);
        if (re.redirect || re.chk_pc) ok = ok && (bp.redirect_pc === re.pc);
`ifdef BP_STATS_EN
        ok = ok && (stat_branches === re.br) && (stat_mispredicts === re.mp);
`endif
        if (ok) begin
          n_pass++;
          $display("[%0d] redir %-13s redirect=%0b pc=%08h ok", cyc, re.name, bp.redirect, bp.redirect_pc);
        end else
          $display("[%0d] FAIL redir %s: got redirect=%0b pc=%08h, want redirect=%0b pc=%08h (stats want %0d/%0d)",
                   cyc, re.name, bp.redirect, bp.redirect_pc, re.redirect, re.pc, re.br, re.mp);
      end
      if (done) begin
        n_checks++;
        if (pq.size() == 0 && rq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pred / %0d redirect expectations left, want 0/0", pq.size(), rq.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
      end
    end
  end

  task automatic step(input bit iv, input logic [31:0] ipc,
                      input bit ev, input bit isbr, input logic [31:0] epc,
                      input bit tk, input logic [31:0] tgt,
                      input bit ptk, input logic [31:0] ptgt, input string nm);
    bit          t, hit, mis;
    logic [31:0] tg, actual;
    int          i;
    @(posedge clk);
    #1;
    bp.if_valid       = iv;
    bp.if_pc          = ipc;
    bp.ex_valid       = ev;
    bp.ex_is_branch   = isbr;
    bp.ex_pc          = epc;
    bp.ex_br_taken    = tk;
    bp.ex_target      = tgt;
    bp.ex_pred_taken  = ptk;
    bp.ex_pred_target = ptgt;
    m_pred(ipc, t, tg);
    pq.push_back('{cyc, iv && t, (iv && t) ? tg : ipc + 32'd4, nm});
    actual = (isbr && tk) ? tgt : epc + 32'd4;
    mis    = ev && (actual != ptgt);
    if (ev && isbr && m_branches != 32'hFFFF_FFFF) m_branches++;
    if (mis && m_misp != 32'hFFFF_FFFF) m_misp++;
    rq.push_back('{cyc + 1, mis, 1'b0, actual, m_branches, m_misp, nm});
    if (ev) begin
      i   = m_idx(epc);
      hit = m_valid[i] && (m_tag[i] == m_tagof(epc));
      if (isbr) begin
        if (hit && tk) begin
          m_ctr[i]    = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
          m_target[i] = tgt;
        end else if (hit) begin
          m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
        end else if (tk) begin
          m_valid[i] = 1; m_tag[i] = m_tagof(epc); m_target[i] = tgt; m_ctr[i] = 2;
        end
      end else if (ptk && hit) begin
        m_valid[i] = 0;
      end
    end
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(4, 6)) << 6) | (32'($urandom_range(0, ENTRIES - 1)) << 2);
  endfunction

  task automatic idle_inputs();
    bp.if_valid = 0; bp.if_pc = 0; bp.ex_valid = 0; bp.ex_is_branch = 0; bp.ex_pc = 0;
    bp.ex_br_taken = 0; bp.ex_target = 0; bp.ex_pred_taken = 0; bp.ex_pred_target = 0;
  endtask

  initial begin
    bit          t;
    logic [31:0] tg, ipc, epc, tgt, ptgt;
    bit          iv, ev, isbr, tk, ptk;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    rq.push_back('{cyc, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, "reset"});
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Directed walk-through of the main scenarios
    step(1, 32'h100, 0, 0, 0,      0, 0,     0, 0,      "reset_pred");
    step(1, 32'h100, 1, 1, 32'h100, 1, 32'h80, 0, 32'h104, "alloc");
    step(1, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80,  "taken2");
    step(1, 32'h100, 1, 1, 32'h100, 1, 32'h80, 1, 32'h80,  "taken3");
    step(1, 32'h100, 1, 1, 32'h100, 0, 32'h80, 1, 32'h80,  "not_taken");
    step(1, 32'h100, 0, 0, 0,      0, 0,     0, 0,      "still_taken");
    step(1, 32'h100, 1, 0, 32'h140, 0, 0,     1, 32'h80,  "alias_miss");
    step(1, 32'h100, 0, 0, 0,      0, 0,     0, 0,      "alias_kept");
    step(1, 32'h100, 1, 0, 32'h100, 0, 0,     1, 32'h80,  "alias_hit");
    step(1, 32'h100, 0, 0, 0,      0, 0,     0, 0,      "invalidated");
    step(1, 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, "wrap");

    for (int n = 0; n < 400; n++) begin
      iv   = ($urandom % 4) != 0;
      ev   = ($urandom % 5) != 0;
      isbr = ($urandom % 3) != 0;
      tk   = $urandom % 2;
      ptk  = $urandom % 2;
      epc  = rand_pc();
      ipc  = (($urandom % 4) == 0) ? epc : rand_pc();
      tgt  = $urandom & 32'hFFFF_FFFC;
      case ($urandom % 3)
        0:       ptgt = epc + 32'd4;
        1:       ptgt = tgt;
        default: begin m_pred(epc, t, tg); ptgt = tg; end
      endcase
      step(iv, ipc, ev, isbr, epc, tk, tgt, ptk, ptgt, "random");
    end

    // Asynchronous reset while redirect is high
    step(0, 0, 1, 1, 32'h200, 1, 32'h300, 0, 32'h204, "pre_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    idle_inputs();
    rq.delete();
    pq.delete();
    model_reset();
    rq.push_back('{cyc, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0, "rst_async"});
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;

    for (int tg_i = 4; tg_i <= 6; tg_i++)
      for (int i = 0; i < ENTRIES; i++)
        step(1, (32'(tg_i) << 6) | (32'(i) << 2), 0, 0, 0, 0, 0, 0, 0, "post_rst");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");
    @(posedge clk);
    #2 done = 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000ns, want finish");
    $fatal(1, "timeout");
  end
endmodule
